// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use bubble, taken-branch flush,
// multi-cycle EX op sequencing and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_mc_start,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_RegWEn,
  input  logic             wb_RegWEn,
  output logic [1:0]       ForwardASel,
  output logic [1:0]       ForwardBSel,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_bubble,
  output logic             ex_mc_done,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  state_t            r_state;
  logic [MC_W-1:0]   r_mc_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;
  logic w_mc_enter;
  logic w_mc_last;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       mem_we, input logic [4:0] mrd,
                                         input logic       wb_we,  input logic [4:0] wrd);
    if (mem_we && mrd != 5'd0 && mrd == rs)     return 2'd2;
    else if (wb_we && wrd != 5'd0 && wrd == rs) return 2'd1;
    else                                        return 2'd0;
  endfunction

  assign ForwardASel = fwd_sel(ex_rs1, mem_RegWEn, mem_rd, wb_RegWEn, wb_rd);
  assign ForwardBSel = fwd_sel(ex_rs2, mem_RegWEn, mem_rd, wb_RegWEn, wb_rd);

  assign w_lu = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

  assign w_mc_enter = (r_state == RUN) & ~ex_br_taken & ex_valid & ex_mc_start;
  assign w_mc_last  = (r_state == MC_BUSY) & (r_mc_cnt == '0);

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    exmem_bubble = 1'b0;
    ex_mc_done   = 1'b0;
    if (r_state == MC_BUSY) begin
      if (w_mc_last) begin
        ex_mc_done = 1'b1;
      end else begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_bubble = 1'b1;
      end
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_mc_enter) begin
      // The op sits in EX from its first cycle, so the hold starts immediately.
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (w_lu) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign ex_busy   = (r_state == MC_BUSY);
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_mc_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mc_enter) begin
            r_state  <= MC_BUSY;
            r_mc_cnt <= MC_W'(MC_CYCLES - 2);
          end
        end
        MC_BUSY: begin
          if (r_mc_cnt == '0) r_state  <= RUN;
          else                r_mc_cnt <= r_mc_cnt - 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_stall_cnt <= '0;
    else if (pc_stall && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding priority, load-use, flush, multi-cycle op, async reset.
module tb_ex_hazard_ctrl;

  localparam int MC_CYCLES = 32;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs2, ex_valid, ex_MemRead, ex_mc_start, ex_br_taken;
  logic             mem_RegWEn, wb_RegWEn;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]       ForwardASel, ForwardBSel;
  logic             pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush, exmem_bubble;
  logic             ex_mc_done, ex_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ex_hazard_ctrl #(.MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_mc_start(ex_mc_start), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_RegWEn(mem_RegWEn), .wb_RegWEn(wb_RegWEn),
    .ForwardASel(ForwardASel), .ForwardBSel(ForwardBSel),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .exmem_bubble(exmem_bubble),
    .ex_mc_done(ex_mc_done), .ex_busy(ex_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_use_rs2 = 0; ex_valid = 0; ex_MemRead = 0; ex_mc_start = 0;
    ex_br_taken = 0; mem_RegWEn = 0; wb_RegWEn = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #3;
    n_cmp++;
    if ({ForwardASel, ForwardBSel, pc_stall, ifid_stall, idex_stall, idex_bubble,
         ifid_flush, exmem_bubble, ex_mc_done, ex_busy} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {ForwardASel, ForwardBSel, pc_stall, ifid_stall, idex_stall, idex_bubble,
                ifid_flush, exmem_bubble, ex_mc_done, ex_busy});
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_RegWEn = 1; wb_rd = 5; wb_RegWEn = 1;
    #1;
    n_cmp++;
    if (ForwardASel !== 2'd2) begin n_err++; $display("FAIL fwdA_mem_prio: got %0d expected 2", ForwardASel); end
    n_cmp++;
    if (ForwardBSel !== 2'd2) begin n_err++; $display("FAIL fwdB_mem_prio: got %0d expected 2", ForwardBSel); end
    mem_RegWEn = 0;
    #1;
    n_cmp++;
    if (ForwardASel !== 2'd1) begin n_err++; $display("FAIL fwdA_wb: got %0d expected 1", ForwardASel); end
    // Separate operands: A matches MEM, B matches WB only.
    mem_RegWEn = 1; ex_rs2 = 9; wb_rd = 9;
    #1;
    n_cmp++;
    if ({ForwardASel, ForwardBSel} !== 4'b1001) begin
      n_err++; $display("FAIL fwd_split: got A=%0d B=%0d expected A=2 B=1", ForwardASel, ForwardBSel);
    end
    wb_RegWEn = 0; mem_RegWEn = 0;
    #1;
    n_cmp++;
    if ({ForwardASel, ForwardBSel} !== 4'b0000) begin
      n_err++; $display("FAIL fwd_none: got A=%0d B=%0d expected 0 0", ForwardASel, ForwardBSel);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    mem_rd = 0; mem_RegWEn = 1; wb_rd = 0; wb_RegWEn = 1; ex_rs2 = 0; ex_rs1 = 0;
    #1;
    n_cmp++;
    if (ForwardBSel !== 2'd0) begin n_err++; $display("FAIL fwdB_x0: got %0d expected 0", ForwardBSel); end
    n_cmp++;
    if (ForwardASel !== 2'd0) begin n_err++; $display("FAIL fwdA_x0: got %0d expected 0", ForwardASel); end
  endtask

  task automatic test_load_use();
    do_reset();
    // rs2 match ignored when the ID op does not read rs2.
    id_valid = 1; id_rs1 = 3; id_rs2 = 7; id_use_rs2 = 0;
    ex_valid = 1; ex_MemRead = 1; ex_rd = 7;
    #1;
    n_cmp++;
    if (pc_stall !== 1'b0) begin n_err++; $display("FAIL lu_no_rs2_use: pc_stall=%0b expected 0", pc_stall); end
    // Load to x0 never hazards.
    id_use_rs2 = 1; ex_rd = 0; id_rs2 = 0;
    #1;
    n_cmp++;
    if (pc_stall !== 1'b0) begin n_err++; $display("FAIL lu_x0: pc_stall=%0b expected 0", pc_stall); end
    ex_rd = 7; id_rs2 = 7;
    #1;
    n_cmp++;
    if ({pc_stall, ifid_stall, idex_bubble, idex_stall, ifid_flush, exmem_bubble} !== 6'b111000) begin
      n_err++;
      $display("FAIL lu_stall: got %b expected 111000",
               {pc_stall, ifid_stall, idex_bubble, idex_stall, ifid_flush, exmem_bubble});
    end
    tick();
    // Bubble now in EX; load moved on.
    ex_valid = 0; ex_MemRead = 0; ex_rd = 0;
    #1;
    n_cmp++;
    if ({pc_stall, ifid_stall, idex_bubble} !== 3'b000) begin
      n_err++; $display("FAIL lu_release: got %b expected 000", {pc_stall, ifid_stall, idex_bubble});
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_flush_vs_lu();
    clear_inputs();
    id_valid = 1; id_rs1 = 4; ex_valid = 1; ex_MemRead = 1; ex_rd = 4; ex_br_taken = 1;
    #1;
    n_cmp++;
    if ({ifid_flush, idex_bubble, pc_stall, ifid_stall, idex_stall} !== 5'b11000) begin
      n_err++;
      $display("FAIL flush_beats_lu: got %b expected 11000",
               {ifid_flush, idex_bubble, pc_stall, ifid_stall, idex_stall});
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL flush_stall_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_multicycle();
    int stalls;
    int done_cyc;
    int done_cnt;
    logic busy_ok;
    do_reset();
    ex_valid = 1; ex_mc_start = 1;
    #1;
    n_cmp++;
    if ({pc_stall, ifid_stall, idex_stall, exmem_bubble, ex_busy} !== 5'b11110) begin
      n_err++;
      $display("FAIL mc_entry: got %b expected 11110",
               {pc_stall, ifid_stall, idex_stall, exmem_bubble, ex_busy});
    end
    stalls = 0; done_cyc = -1; done_cnt = 0; busy_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (pc_stall) stalls++;
      if (ex_mc_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (c >= 1 && c <= 31 && !ex_busy) busy_ok = 1'b0;
      if (c > 31 && ex_busy) busy_ok = 1'b0;
      tick();
      if (c == 0) ex_mc_start = 0;
      if (c == 31) ex_valid = 0;
      #1;
    end
    n_cmp++;
    if (stalls != 31) begin n_err++; $display("FAIL mc_stall_cycles: got %0d expected 31", stalls); end
    n_cmp++;
    if (done_cyc != 31 || done_cnt != 1) begin
      n_err++; $display("FAIL mc_done_cycle: got cycle %0d count %0d expected cycle 31 count 1", done_cyc, done_cnt);
    end
    n_cmp++;
    if (!busy_ok) begin n_err++; $display("FAIL mc_busy_window: got mismatched ex_busy expected high cycles 1..31"); end
    n_cmp++;
    if (stall_cnt !== 16'd31) begin n_err++; $display("FAIL mc_stall_cnt: got %0d expected 31", stall_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    ex_valid = 1; ex_mc_start = 1;
    tick();
    ex_mc_start = 0;
    for (int i = 0; i < 9; i++) tick();
    n_cmp++;
    if (ex_busy !== 1'b1 || stall_cnt !== 16'd10) begin
      n_err++; $display("FAIL busy_before_rst: got busy=%0b cnt=%0d expected busy=1 cnt=10", ex_busy, stall_cnt);
    end
    #1;
    rst = 1;
    #1;
    n_cmp++;
    if (ex_busy !== 1'b0 || stall_cnt !== 16'd0 || pc_stall !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got busy=%0b cnt=%0d pc_stall=%0b expected 0 0 0", ex_busy, stall_cnt, pc_stall);
    end
    tick();
    rst = 0;
    ex_valid = 0;
    tick();
    n_cmp++;
    if (ex_busy !== 1'b0 || pc_stall !== 1'b0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL run_after_rst: got busy=%0b pc_stall=%0b cnt=%0d expected 0 0 0", ex_busy, pc_stall, stall_cnt);
    end
    // Back in RUN: a new load-use must stall again.
    id_valid = 1; id_rs1 = 12; ex_valid = 1; ex_MemRead = 1; ex_rd = 12;
    #1;
    n_cmp++;
    if (pc_stall !== 1'b1 || idex_bubble !== 1'b1) begin
      n_err++; $display("FAIL lu_after_rst: got pc_stall=%0b bubble=%0b expected 1 1", pc_stall, idex_bubble);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_x0();
    test_load_use();
    test_flush_vs_lu();
    test_multicycle();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
